// File: rtl/interrupt_claim_controller.sv
// interrupt_claim_controller
// Front-end of a platform interrupt controller. Raw IRQ lines pass a gateway
// into pending_q, eligible sources go through a priority search (highest
// priority wins, lowest index breaks ties) whose result is registered, and a
// small IDLE -> EVAL -> RESP FSM serves the hart's claim/complete handshake.
//
// Handshake: i_claim is a request strobe that is only sampled while the FSM is
// IDLE; requests in EVAL/RESP are dropped, not queued. The result is returned
// two cycles later as a one-cycle o_claim_ack pulse, with o_claim_hit/o_claim_id
// valid in that same cycle. There is no ready signal; the hart must wait for the
// ack. i_complete is a fire-and-forget strobe qualified by i_complete_id.
//
// Optional build macro: INTC_EDGE_TRIGGER_EN selects rising-edge gateways
// (one src_q register per source); undefined gives level-sensitive gateways.
// The FSM state is held in state_q (enum state_t) for hierarchical probing.
module interrupt_claim_controller #(
  parameter int W = 2,
  parameter int N = 4,
  localparam int M = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic [N-1:0] i_sources,
  input  logic         i_cfg_we,
  input  logic [M-1:0] i_cfg_idx,
  input  logic [W-1:0] i_cfg_prio,
  input  logic         i_thr_we,
  input  logic [W-1:0] i_thr,
  input  logic         i_claim,
  output logic         o_claim_ack,
  output logic [M-1:0] o_claim_id,
  output logic         o_claim_hit,
  input  logic         i_complete,
  input  logic [M-1:0] i_complete_id,
  output logic         o_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   prio_q [N];
  logic [W-1:0]   thr_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   in_service_q;
  logic           best_vld_q;
  logic [M-1:0]   best_idx_q;
  logic [W-1:0]   best_prio_q;

  logic [N-1:0]   src_evt;
  logic [N-1:0]   eligible;
  logic [N-1:0]   claim_mask;
  logic [N-1:0]   complete_mask;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   in_service_d;
  logic [W-1:0]   thr_d;
  logic           tree_vld;
  logic [M-1:0]   tree_idx;
  logic [W-1:0]   tree_prio;

`ifdef INTC_EDGE_TRIGGER_EN
  logic [N-1:0]   src_q;

  // Delay the raw lines by one cycle so the gateway sees only rising edges
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) src_q <= '0;
    else          src_q <= i_sources;
  end

  assign src_evt = i_sources & ~src_q;
`else
  assign src_evt = i_sources;
`endif

  // Eligibility mask feeding the search: pending, not in service, prio != 0
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = pending_q[i] && !in_service_q[i] && (prio_q[i] != '0);
    end
  end

  // Priority search: strictly greater replaces, so equal priorities keep the lower index
  always_comb begin
    tree_vld  = 1'b0;
    tree_idx  = '0;
    tree_prio = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i] && (!tree_vld || (prio_q[i] > tree_prio))) begin
        tree_vld  = 1'b1;
        tree_idx  = M'(i);
        tree_prio = prio_q[i];
      end
    end
  end

  // Gateway and in-service next state; a committing claim overrides both a new
  // source event and a same-cycle completion of the same id
  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    if ((state_q == RESP) && o_claim_hit) claim_mask[o_claim_id] = 1'b1;
    if (i_complete) complete_mask[i_complete_id] = 1'b1;
    pending_d    = (pending_q | (src_evt & ~in_service_q)) & ~claim_mask;
    in_service_d = (in_service_q & ~complete_mask) | claim_mask;
    thr_d        = i_thr_we ? i_thr : thr_q;
  end

  // Configuration, gateway state, registered search result and o_irq
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N; i++) prio_q[i] <= '0;
      thr_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      best_vld_q   <= 1'b0;
      best_idx_q   <= '0;
      best_prio_q  <= '0;
      o_irq        <= 1'b0;
    end else begin
      if (i_cfg_we) prio_q[i_cfg_idx] <= i_cfg_prio;
      thr_q        <= thr_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      best_vld_q   <= tree_vld;
      best_idx_q   <= tree_idx;
      best_prio_q  <= tree_prio;
      // Threshold writes show up on o_irq one cycle after the strobe
      o_irq        <= best_vld_q && (best_prio_q > thr_d);
    end
  end

  // Claim FSM; the claim result is registered on the EVAL -> RESP transition
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      o_claim_ack <= 1'b0;
      o_claim_hit <= 1'b0;
      o_claim_id  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          o_claim_ack <= 1'b0;
          o_claim_hit <= 1'b0;
          o_claim_id  <= '0;
          if (i_claim) state_q <= EVAL;
        end
        EVAL: begin
          state_q     <= RESP;
          o_claim_ack <= 1'b1;
          if (best_vld_q && (best_prio_q > thr_q)) begin
            o_claim_hit <= 1'b1;
            o_claim_id  <= best_idx_q;
          end else begin
            o_claim_hit <= 1'b0;
            o_claim_id  <= '0;
          end
        end
        RESP: begin
          state_q     <= IDLE;
          o_claim_ack <= 1'b0;
          o_claim_hit <= 1'b0;
          o_claim_id  <= '0;
        end
        default: begin
          state_q     <= IDLE;
          o_claim_ack <= 1'b0;
          o_claim_hit <= 1'b0;
          o_claim_id  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_claim_controller.sv
// tb_interrupt_claim_controller
// Directed scenarios followed by random traffic; every cycle the DUT outputs
// are compared with a cycle-level reference model of the controller.
module tb_interrupt_claim_controller;

  localparam int W = 2;
  localparam int N = 4;
  localparam int M = 2;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] i_sources;
  logic         i_cfg_we;
  logic [M-1:0] i_cfg_idx;
  logic [W-1:0] i_cfg_prio;
  logic         i_thr_we;
  logic [W-1:0] i_thr;
  logic         i_claim;
  logic         o_claim_ack;
  logic [M-1:0] o_claim_id;
  logic         o_claim_hit;
  logic         i_complete;
  logic [M-1:0] i_complete_id;
  logic         o_irq;

  always #5 clk = ~clk;

  interrupt_claim_controller #(.W(W), .N(N)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_sources     (i_sources),
    .i_cfg_we      (i_cfg_we),
    .i_cfg_idx     (i_cfg_idx),
    .i_cfg_prio    (i_cfg_prio),
    .i_thr_we      (i_thr_we),
    .i_thr         (i_thr),
    .i_claim       (i_claim),
    .o_claim_ack   (o_claim_ack),
    .o_claim_id    (o_claim_id),
    .o_claim_hit   (o_claim_hit),
    .i_complete    (i_complete),
    .i_complete_id (i_complete_id),
    .o_irq         (o_irq)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [M-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Sets of sources held as bit masks, priorities as plain ints; the model
  // follows the documented pipeline: pending -> best (+1) -> irq (+1).
  int           m_prio [N];
  int           m_thr;
  logic [N-1:0] m_pend, m_insv, m_src_prev;
  logic         m_bvld;
  int           m_bidx, m_bprio;
  logic         m_irq;
  int           m_phase;   // 0 idle, 1 evaluating, 2 responding
  logic         m_ack, m_hit;
  int           m_id;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_prio[i] = 0;
    m_thr = 0; m_pend = '0; m_insv = '0; m_src_prev = '0;
    m_bvld = 1'b0; m_bidx = 0; m_bprio = 0; m_irq = 1'b0;
    m_phase = 0; m_ack = 1'b0; m_hit = 1'b0; m_id = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] evt, granted, completed;
    logic         nb_vld, n_hit, n_ack;
    int           nb_idx, nb_prio, n_thr, n_id, n_phase;
`ifdef INTC_EDGE_TRIGGER_EN
    evt = i_sources & ~m_src_prev;
`else
    evt = i_sources;
`endif
    // Best candidate: highest non-zero priority, first index found keeps ties
    nb_vld = 1'b0; nb_idx = 0; nb_prio = 0;
    for (int i = 0; i < N; i++)
      if (m_pend[i] && !m_insv[i] && m_prio[i] > nb_prio) begin
        nb_vld = 1'b1; nb_idx = i; nb_prio = m_prio[i];
      end
    granted   = (m_ack && m_hit) ? N'(1 << m_id) : '0;
    completed = i_complete ? N'(1 << i_complete_id) : '0;
    n_thr     = i_thr_we ? int'(i_thr) : m_thr;
    n_ack = 1'b0; n_hit = 1'b0; n_id = 0;
    if (m_phase == 1) begin
      n_ack = 1'b1;
      n_hit = m_bvld && (m_bprio > m_thr);
      n_id  = n_hit ? m_bidx : 0;
    end
    n_phase = (m_phase == 0) ? (i_claim ? 1 : 0) : (m_phase == 1) ? 2 : 0;
    // Commit
    m_irq      = m_bvld && (m_bprio > n_thr);
    m_bvld     = nb_vld; m_bidx = nb_idx; m_bprio = nb_prio;
    m_pend     = (m_pend | (evt & ~m_insv)) & ~granted;
    m_insv     = (m_insv & ~completed) | granted;
    if (i_cfg_we) m_prio[i_cfg_idx] = int'(i_cfg_prio);
    m_thr      = n_thr;
    m_src_prev = i_sources;
    m_ack = n_ack; m_hit = n_hit; m_id = n_id; m_phase = n_phase;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle();
    if (!rst_n) model_reset();
    else        model_step();
    @(posedge clk);
    @(negedge clk);
    check("ack", o_claim_ack, m_ack);
    check("hit", o_claim_hit, m_hit);
    check("id",  o_claim_id,  m_id);
    check("irq", o_irq,       m_irq);
    i_cfg_we = 1'b0; i_thr_we = 1'b0; i_claim = 1'b0; i_complete = 1'b0;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_prio(input int idx, input int p);
    i_cfg_we = 1'b1; i_cfg_idx = M'(idx); i_cfg_prio = W'(p);
    cycle();
  endtask

  task automatic set_thr(input int t);
    i_thr_we = 1'b1; i_thr = W'(t);
    cycle();
  endtask

  task automatic complete(input int id);
    i_complete = 1'b1; i_complete_id = M'(id);
    cycle();
  endtask

  // Claim and compare the response with scenario-level expectations
  task automatic claim_expect(input string tag, input int exp_hit, input int exp_id);
    i_claim = 1'b1;
    cycle();
    cycle();
    check({tag, "_ack"}, o_claim_ack, 1);
    check({tag, "_hit"}, o_claim_hit, exp_hit);
    check({tag, "_id"},  o_claim_id,  exp_id);
    cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    i_sources = '0; i_cfg_we = 1'b0; i_cfg_idx = '0; i_cfg_prio = '0;
    i_thr_we = 1'b0; i_thr = '0; i_claim = 1'b0; i_complete = 1'b0; i_complete_id = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ack", o_claim_ack, 0);
    check("rst_hit", o_claim_hit, 0);
    check("rst_id",  o_claim_id,  0);
    check("rst_irq", o_irq,       0);
    rst_n = 1'b1;

    // Basic latency: source high -> o_irq three edges later, then claim it
    set_prio(2, 3);
    i_sources = 4'b0100;
    cycle();
    cycle();
    check("lat_irq_early", o_irq, 0);
    cycle();
    check("lat_irq", o_irq, 1);
    claim_expect("basic", 1, 2);
    i_sources = '0;
    complete(2);
    wait_n(3);

    // Priority ordering with a tie between sources 1 and 2
    set_prio(0, 1); set_prio(1, 3); set_prio(3, 2);
    i_sources = 4'b1110;
    wait_n(3);
    exp_q.push_back(M'(1)); exp_q.push_back(M'(2)); exp_q.push_back(M'(3));
    while (exp_q.size() > 0) claim_expect("order", 1, int'(exp_q.pop_front()));
    claim_expect("order_empty", 0, 0);
    i_sources = '0;
    complete(1); complete(2); complete(3);
    wait_n(3);

    // Threshold masking and threshold write latency
    set_prio(0, 2);
    set_thr(2);
    i_sources = 4'b0001;
    cycle();
    i_sources = '0;
    wait_n(3);
    check("thr_mask_irq", o_irq, 0);
    claim_expect("thr_mask", 0, 0);
    i_thr_we = 1'b1; i_thr = 2'd1;
    cycle();
    check("thr_write_irq", o_irq, 1);
    claim_expect("thr_pass", 1, 0);
    complete(0);
    wait_n(3);

    // Completion with the source still high; completion of an idle id
    i_sources = 4'b0010;
    wait_n(3);
    claim_expect("rep", 1, 1);
    complete(1);
    wait_n(3);
`ifdef INTC_EDGE_TRIGGER_EN
    check("repend_irq", o_irq, 0);
`else
    check("repend_irq", o_irq, 1);
`endif
    complete(3);
    cycle();
`ifdef INTC_EDGE_TRIGGER_EN
    check("noop_cmp_irq", o_irq, 0);
`else
    check("noop_cmp_irq", o_irq, 1);
`endif
    i_sources = '0;
`ifndef INTC_EDGE_TRIGGER_EN
    claim_expect("rep2", 1, 1);
    complete(1);
`endif
    wait_n(3);

    // Claim while busy is dropped; completion racing the claim loses
    set_prio(2, 2);
    i_sources = 4'b0100;
    cycle();
    i_sources = '0;
    wait_n(3);
    i_claim = 1'b1;
    cycle();
    i_claim = 1'b1;
    cycle();
    check("race_ack", o_claim_ack, 1);
    check("race_id",  o_claim_id,  2);
    i_claim = 1'b1; i_complete = 1'b1; i_complete_id = 2'd2;
    cycle();
    check("race_insv", dut.in_service_q[2], 1);
    wait_n(2);
    check("busy_claim_dropped", o_claim_ack, 0);
    complete(2);
    wait_n(2);

    // Reset while evaluating a claim
    i_sources = 4'b0100;
    cycle();
    i_sources = '0;
    wait_n(3);
    i_claim = 1'b1;
    cycle();
    rst_n = 1'b0;
    #1;
    model_reset();
    check("mid_rst_ack", o_claim_ack, 0);
    check("mid_rst_hit", o_claim_hit, 0);
    check("mid_rst_id",  o_claim_id,  0);
    check("mid_rst_irq", o_irq,       0);
    cycle();
    rst_n = 1'b1;
    wait_n(3);
    check("mid_rst_no_ack", o_claim_ack, 0);

`ifdef INTC_EDGE_TRIGGER_EN
    // Held level yields one claim only
    set_prio(3, 2);
    i_sources = 4'b1000;
    wait_n(3);
    claim_expect("edge_first", 1, 3);
    complete(3);
    wait_n(4);
    claim_expect("edge_second", 0, 0);
    i_sources = '0;
    cycle();
`endif

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      i_sources = N'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        i_cfg_we = 1'b1; i_cfg_idx = M'($urandom_range(0, N-1)); i_cfg_prio = W'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 15) == 0) begin
        i_thr_we = 1'b1; i_thr = W'($urandom_range(0, 3));
      end
      i_claim = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) begin
        i_complete = 1'b1; i_complete_id = M'($urandom_range(0, N-1));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
